b01_stim_seq: RTL and testbench
===============================

# b01_stim_seq

Stimulus sequencer and response collector for the b01 serial-adder datapath. It holds a small programmable stimulus memory of 3-bit opcodes and, on a start handshake, steps through it: it holds the DUT in reset for a fixed number of cycles, then drives `line1`/`line2`/`obs` one opcode per cycle. It compacts the DUT's `outp`/`overflw` responses into counters and a signature, replacing free-running bench-side program counters with a controllable, restartable run engine.

## Interface
- `DEPTH`, 10: stimulus memory entries.
- `AW`, 4: address/length width; requires `2**AW >= DEPTH`.
- `CNTW`, 16: response counter width.
- `RST_CYC`, 2: DUT reset cycles per run; valid range 1..15.

- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the `clock` rising edge.
- `prog_we`  in  1  stimulus memory write strobe.
- `prog_addr`  in  AW  write address.
- `prog_data`  in  3  opcode: [0]=line1, [1]=line2, [2]=obs.
- `len`  in  AW  steps per run, sampled at start.
- `start`  in  1  run request, level-sampled.
- `abort`  in  1  cancel the run in progress.
- `outp_in`, `overflw_in`  in  1 each  DUT responses.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle completion pulse.
- `dut_reset`  out  1  active-high reset to the DUT.
- `line1`, `line2`, `obs`  out  1 each  registered DUT stimulus.
- `ones_cnt`, `ovf_cnt`  out  CNTW each  counts of samples with outp=1 and overflw=1.
- `sig`  out  8  response signature.

## Operation
- States: IDLE, RST, RUN, DRAIN, DONE.
- Reset (`reset`=0): state IDLE; busy=0; done=0; dut_reset=1; line1, line2 and obs=0; counters, sig, pc and rst_cnt=0. Memory contents are not reset.
- IDLE:
  - `prog_we`=1 writes `mem[prog_addr]<=prog_data`. Addresses >= DEPTH are dropped.
  - `start`=1 latches `len_q`. If `len`=0 or `len`>DEPTH, `len_q`=DEPTH.
  - On start, counters and sig clear, and the state goes to RST.
- RST: dut_reset=1 for RST_CYC cycles, then RUN with pc=0.
- RUN: each edge loads `{obs,line2,line1}<=mem[pc]` and does pc++. The edge with pc=len_q-1 goes to DRAIN.
- Sampling: each edge that ends a stimulus cycle samples outp_in and overflw_in. These are RUN edges 2..len_q plus the DRAIN edge, so exactly len_q samples per run.
- Per sample:
  - ones_cnt += outp_in; ovf_cnt += overflw_in. Both saturate at all-ones.
  - sig <= {sig[6:0],sig[7]} ^ {6'b0,overflw_in,outp_in}.
- DRAIN: one cycle, then DONE. On the DRAIN edge, line1, line2 and obs return to 0.
- DONE: done=1 for one cycle, then IDLE. Results hold until the next start.
- busy=1 in RST, RUN and DRAIN. dut_reset=1 in IDLE, RST and DONE; it is 0 in RUN and DRAIN.
- start while busy or in DONE: ignored. prog_we while not in IDLE: ignored.
- abort=1 in RST, RUN or DRAIN forces the following on the next edge:
  - state IDLE; dut_reset=1; line1, line2 and obs=0.
  - No done pulse; partial results are retained.
  - abort takes precedence over all other transitions. It is ignored in IDLE and DONE.

## Timing
- Start accepted at edge E0 (IDLE, start=1).
- dut_reset deasserts after edge E0+RST_CYC.
- First stimulus is valid during the cycle after edge E0+RST_CYC+1.
- done is high during the cycle after edge E0+RST_CYC+len_q+1.
- busy falls at the same edge that raises done.
- Stimulus outputs are registered: the value presented at step k is `mem[k]`, held exactly one cycle.
- Back-to-back runs: earliest restart is start=1 in the first IDLE cycle after DONE.
- Reset mid-run overrides everything on that edge.

## Test plan
- Reset behaviour: `reset`=0 for 2 cycles with start=1 -> busy=0, done=0, dut_reset=1, line1/line2/obs=0, counters and sig=0.
- Basic run: program mem[0..2]=3'b011,3'b101,3'b000; len=3; outp_in=1, overflw_in=0 -> stimulus sequence (line1,line2,obs)=(1,1,0),(1,0,1),(0,0,0); ones_cnt=3, ovf_cnt=0, sig=8'h07; done high 6 cycles after start.
- Length clamp: len=0 -> 10 stimulus cycles; ones_cnt=10 with outp_in=1.
- Abort: abort at the 2nd RUN cycle -> IDLE next edge, no done pulse, dut_reset=1; a new start then behaves normally.
- Ignored requests: a start pulse mid-run and a prog_we to mem[0] mid-run -> no effect; the next run replays the original mem[0].
- Saturation: CNTW=2, len=7, outp_in=1 -> ones_cnt=3.

Source files
------------

// File: rtl/b01_stim_seq_if.sv
// Control/programming handshake between a test controller and the b01 stimulus sequencer.
interface b01_stim_seq_if #(
    parameter int AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [2:0]    prog_data;
    logic [AW-1:0] len;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;

    modport master (
        output prog_we, prog_addr, prog_data, len, start, abort,
        input  busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, len, start, abort,
        output busy, done
    );
endinterface

// File: rtl/b01_stim_seq.sv
// Stimulus sequencer and response collector for the b01 serial adder: replays a programmed
// opcode list after a DUT reset window and compacts outp/overflw into counters and a signature.
module b01_stim_seq #(
    parameter int DEPTH   = 10,
    parameter int AW      = 4,
    parameter int CNTW    = 16,
    parameter int RST_CYC = 2
) (
    input  logic             clock,
    input  logic             reset,
    b01_stim_seq_if.slave    ctl,
    output logic             dut_reset,
    output logic             line1,
    output logic             line2,
    output logic             obs,
    input  logic             outp_in,
    input  logic             overflw_in,
    output logic [CNTW-1:0]  ones_cnt,
    output logic [CNTW-1:0]  ovf_cnt,
    output logic [7:0]       sig
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // len/pc carry one extra bit so DEPTH == 2**AW still fits
    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [3:0]  RST_LAST = 4'(RST_CYC - 1);

    logic [2:0]      mem_q [DEPTH];
    state_t          state_q;
    logic [AW:0]     len_q;
    logic [AW:0]     pc_q;
    logic [3:0]      rst_cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            dut_reset_q;
    logic            line1_q;
    logic            line2_q;
    logic            obs_q;
    logic [CNTW-1:0] ones_q;
    logic [CNTW-1:0] ovf_q;
    logic [7:0]      sig_q;

    logic [AW:0]     len_d;
    logic [CNTW-1:0] ones_d;
    logic [CNTW-1:0] ovf_d;
    logic [7:0]      sig_d;
    logic            sample_s;
    logic            active_s;

    // Clamp the requested run length into 1..DEPTH
    always_comb begin
        len_d = {1'b0, ctl.len};
        if (ctl.len == {AW{1'b0}} || {1'b0, ctl.len} > DEPTH_L) begin
            len_d = DEPTH_L;
        end else begin
            len_d = {1'b0, ctl.len};
        end
    end

    // Response compaction; the first RUN edge has no response yet to sample
    always_comb begin
        active_s = (state_q == RST) || (state_q == RUN) || (state_q == DRAIN);
        sample_s = ((state_q == RUN) && (pc_q != {(AW+1){1'b0}})) || (state_q == DRAIN);
        ones_d   = ones_q;
        ovf_d    = ovf_q;
        if (outp_in && (ones_q != {CNTW{1'b1}})) begin
            ones_d = ones_q + CNTW'(1);
        end else begin
            ones_d = ones_q;
        end
        if (overflw_in && (ovf_q != {CNTW{1'b1}})) begin
            ovf_d = ovf_q + CNTW'(1);
        end else begin
            ovf_d = ovf_q;
        end
        sig_d = {sig_q[6:0], sig_q[7]} ^ {6'b000000, overflw_in, outp_in};
    end

    // Stimulus memory: writable only while idle, out-of-range addresses dropped
    always_ff @(posedge clock) begin
        if (reset && (state_q == IDLE) && ctl.prog_we && ({1'b0, ctl.prog_addr} < DEPTH_L)) begin
            mem_q[ctl.prog_addr] <= ctl.prog_data;
        end
    end

    // Run-engine FSM with registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= {(AW+1){1'b0}};
            pc_q        <= {(AW+1){1'b0}};
            rst_cnt_q   <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dut_reset_q <= 1'b1;
            line1_q     <= 1'b0;
            line2_q     <= 1'b0;
            obs_q       <= 1'b0;
            ones_q      <= {CNTW{1'b0}};
            ovf_q       <= {CNTW{1'b0}};
            sig_q       <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (ctl.abort && active_s) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                dut_reset_q <= 1'b1;
                line1_q     <= 1'b0;
                line2_q     <= 1'b0;
                obs_q       <= 1'b0;
            end else begin
                if (sample_s) begin
                    ones_q <= ones_d;
                    ovf_q  <= ovf_d;
                    sig_q  <= sig_d;
                end
                case (state_q)
                    IDLE: begin
                        if (ctl.start) begin
                            state_q     <= RST;
                            len_q       <= len_d;
                            rst_cnt_q   <= 4'd0;
                            busy_q      <= 1'b1;
                            dut_reset_q <= 1'b1;
                            ones_q      <= {CNTW{1'b0}};
                            ovf_q       <= {CNTW{1'b0}};
                            sig_q       <= 8'h00;
                        end
                    end
                    RST: begin
                        if (rst_cnt_q == RST_LAST) begin
                            state_q     <= RUN;
                            pc_q        <= {(AW+1){1'b0}};
                            dut_reset_q <= 1'b0;
                        end else begin
                            rst_cnt_q <= rst_cnt_q + 4'd1;
                        end
                    end
                    RUN: begin
                        {obs_q, line2_q, line1_q} <= mem_q[pc_q[AW-1:0]];
                        pc_q <= pc_q + (AW+1)'(1);
                        if (pc_q == len_q - (AW+1)'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        dut_reset_q <= 1'b1;
                        line1_q     <= 1'b0;
                        line2_q     <= 1'b0;
                        obs_q       <= 1'b0;
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        dut_reset_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ctl.busy  = busy_q;
    assign ctl.done  = done_q;
    assign dut_reset = dut_reset_q;
    assign line1     = line1_q;
    assign line2     = line2_q;
    assign obs       = obs_q;
    assign ones_cnt  = ones_q;
    assign ovf_cnt   = ovf_q;
    assign sig       = sig_q;

endmodule

// File: tb/tb_b01_stim_seq.sv
// Directed, table-driven bench for b01_stim_seq with hand-written abort, reset and saturation cases.
module tb_b01_stim_seq;

    localparam int RST_CYC = 2;

    logic        clk;
    logic        rst_n;
    logic        dut_reset, line1, line2, obs;
    logic        outp, ovf;
    logic [15:0] ones_cnt, ovf_cnt;
    logic [7:0]  sig;

    logic        s_dut_reset, s_line1, s_line2, s_obs;
    logic [1:0]  s_ones, s_ovf;
    logic [7:0]  s_sig;

    b01_stim_seq_if #(.AW(4)) ctl ();
    b01_stim_seq_if #(.AW(4)) sctl ();

    b01_stim_seq #(.DEPTH(10), .AW(4), .CNTW(16), .RST_CYC(RST_CYC)) u_dut (
        .clock(clk), .reset(rst_n), .ctl(ctl),
        .dut_reset(dut_reset), .line1(line1), .line2(line2), .obs(obs),
        .outp_in(outp), .overflw_in(ovf),
        .ones_cnt(ones_cnt), .ovf_cnt(ovf_cnt), .sig(sig)
    );

    b01_stim_seq #(.DEPTH(10), .AW(4), .CNTW(2), .RST_CYC(RST_CYC)) u_sat (
        .clock(clk), .reset(rst_n), .ctl(sctl),
        .dut_reset(s_dut_reset), .line1(s_line1), .line2(s_line2), .obs(s_obs),
        .outp_in(outp), .overflw_in(ovf),
        .ones_cnt(s_ones), .ovf_cnt(s_ovf), .sig(s_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  len;
        logic        outp;
        logic        ovf;
        logic        inj;
        logic [15:0] e_ones;
        logic [15:0] e_ovf;
        logic [7:0]  e_sig;
        int          e_lat;
    } vec_t;

    vec_t       vecs [8];
    logic [2:0] mem_m [10];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic prog(input logic [3:0] a, input logic [2:0] d);
        ctl.prog_we   = 1'b1;
        ctl.prog_addr = a;
        ctl.prog_data = d;
        @(negedge clk);
        ctl.prog_we = 1'b0;
        if (a < 4'd10) mem_m[a] = d;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE
    task automatic run_vec(input vec_t v);
        logic [2:0] stim_q [$];
        int         cyc;
        int         lenq;
        logic [2:0] e;
        lenq = (v.len == 4'd0 || v.len > 4'd10) ? 10 : int'(v.len);
        outp = v.outp;
        ovf  = v.ovf;
        ctl.len   = v.len;
        ctl.start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (ctl.done !== 1'b1 && cyc < 60) begin
            if (dut_reset == 1'b0) stim_q.push_back({obs, line2, line1});
            if (v.inj && stim_q.size() == 2) begin
                ctl.start     = 1'b1;
                ctl.prog_we   = 1'b1;
                ctl.prog_addr = 4'd0;
                ctl.prog_data = 3'b110;
            end else begin
                ctl.start   = 1'b0;
                ctl.prog_we = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        ctl.start   = 1'b0;
        ctl.prog_we = 1'b0;
        chk("done_latency", 32'(cyc), 32'(v.e_lat));
        chk("busy_at_done", 32'(ctl.busy), 32'd0);
        chk("dut_reset_at_done", 32'(dut_reset), 32'd1);
        chk("lines_at_done", 32'({obs, line2, line1}), 32'd0);
        chk("ones_cnt", 32'(ones_cnt), 32'(v.e_ones));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(v.e_ovf));
        chk("sig", 32'(sig), 32'(v.e_sig));
        chk("stim_len", 32'(stim_q.size()), 32'(lenq + 1));
        for (int i = 0; i < stim_q.size() && i <= lenq; i++) begin
            e = (i == 0) ? 3'b000 : mem_m[i-1];
            chk($sformatf("stim_step%0d", i), 32'(stim_q[i]), 32'(e));
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(ctl.done), 32'd0);
    endtask

    initial begin : main
        int   cyc;
        logic seen;

        // len=3 basic / ignored-request / replay; clamps; single step; quiet run; mixed responses
        vecs[0] = '{4'd3,  1'b1, 1'b0, 1'b0, 16'd3,  16'd0,  8'h07, 6};
        vecs[1] = '{4'd3,  1'b1, 1'b0, 1'b1, 16'd3,  16'd0,  8'h07, 6};
        vecs[2] = '{4'd3,  1'b1, 1'b0, 1'b0, 16'd3,  16'd0,  8'h07, 6};
        vecs[3] = '{4'd0,  1'b1, 1'b0, 1'b0, 16'd10, 16'd0,  8'hFC, 13};
        vecs[4] = '{4'd12, 1'b0, 1'b1, 1'b0, 16'd0,  16'd10, 8'hF9, 13};
        vecs[5] = '{4'd1,  1'b1, 1'b1, 1'b0, 16'd1,  16'd1,  8'h03, 4};
        vecs[6] = '{4'd10, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0,  8'h00, 13};
        vecs[7] = '{4'd5,  1'b1, 1'b1, 1'b0, 16'd5,  16'd5,  8'h21, 8};

        rst_n = 1'b0;
        outp = 1'b0; ovf = 1'b0;
        ctl.prog_we = 1'b0; ctl.prog_addr = 4'd0; ctl.prog_data = 3'd0;
        ctl.len = 4'd3; ctl.start = 1'b1; ctl.abort = 1'b0;
        sctl.prog_we = 1'b0; sctl.prog_addr = 4'd0; sctl.prog_data = 3'd0;
        sctl.len = 4'd0; sctl.start = 1'b0; sctl.abort = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(ctl.busy), 32'd0);
        chk("rst_done", 32'(ctl.done), 32'd0);
        chk("rst_dut_reset", 32'(dut_reset), 32'd1);
        chk("rst_lines", 32'({obs, line2, line1}), 32'd0);
        chk("rst_counters", {ones_cnt, ovf_cnt}, 32'd0);
        chk("rst_sig", 32'(sig), 32'd0);
        rst_n = 1'b1;
        ctl.start = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 32'(ctl.busy), 32'd0);

        prog(4'd0, 3'b011); prog(4'd1, 3'b101); prog(4'd2, 3'b000);
        prog(4'd3, 3'b111); prog(4'd4, 3'b110); prog(4'd5, 3'b001);
        prog(4'd6, 3'b010); prog(4'd7, 3'b100); prog(4'd8, 3'b011);
        prog(4'd9, 3'b101);

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Abort during the 2nd RUN cycle: no sample, no done, immediate return to IDLE
        outp = 1'b1;
        ctl.len = 4'd5; ctl.start = 1'b1;
        @(negedge clk);
        ctl.start = 1'b0;
        cyc = 0;
        while (dut_reset !== 1'b0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_run", 32'(dut_reset), 32'd0);
        @(negedge clk);
        ctl.abort = 1'b1;
        @(negedge clk);
        ctl.abort = 1'b0;
        chk("abort_busy", 32'(ctl.busy), 32'd0);
        chk("abort_dut_reset", 32'(dut_reset), 32'd1);
        chk("abort_lines", 32'({obs, line2, line1}), 32'd0);
        chk("abort_ones_kept", 32'(ones_cnt), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ctl.done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_vec(vecs[0]);

        // Reset in the first RUN cycle wins over the stimulus load
        ctl.len = 4'd5; ctl.start = 1'b1;
        @(negedge clk);
        ctl.start = 1'b0;
        cyc = 0;
        while (dut_reset !== 1'b0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 32'(ctl.busy), 32'd0);
        chk("midrst_dut_reset", 32'(dut_reset), 32'd1);
        chk("midrst_lines", 32'({obs, line2, line1}), 32'd0);
        @(negedge clk);

        // 2-bit counters saturate over a 7-sample run
        outp = 1'b1; ovf = 1'b0;
        sctl.len = 4'd7; sctl.start = 1'b1;
        @(negedge clk);
        sctl.start = 1'b0;
        cyc = 0;
        while (sctl.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("sat_done_latency", 32'(cyc), 32'(RST_CYC + 7 + 1));
        chk("sat_ones", 32'(s_ones), 32'd3);
        chk("sat_ovf", 32'(s_ovf), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
